// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable word array behind a fixed-latency
// IDLE/WAIT/RESP controller, with error pulses for illegal requests.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for a request with a nonzero mask
    // WAIT  | latency countdown; access happens on the edge where cnt==0
    // RESP  | one-cycle response; never accepts, so a held request is not re-taken
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [29:0]   addr_q;
    logic [3:0]    rmask_q;
    logic [3:0]    wmask_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [30:0]   word_off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          wmask_ok;
    logic          req_err;
    logic          do_access;
    logic          mem_we;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^dmem_addr[1:0];

    // Extra borrow bit keeps addresses below BASE_ADDR from wrapping into range.
    assign word_off  = {1'b0, addr_q} - {1'b0, BASE_ADDR[31:2]};
    assign in_range  = (word_off[30:AW] == '0);
    assign idx       = word_off[AW-1:0];

    always_comb begin
        wmask_ok = 1'b0;
        case (wmask_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: wmask_ok = 1'b1;
            default:                   wmask_ok = 1'b0;
        endcase
    end

    assign req_err   = ((|rmask_q) && (|wmask_q)) || !in_range || ((|wmask_q) && !wmask_ok);
    assign do_access = (state == WAIT) && (cnt == 4'd0);
    assign mem_we    = do_access && !req_err && (|wmask_q);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            rmask_q    <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            dmem_rdata <= '0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dmem_resp  <= 1'b0;
                    dmem_err   <= 1'b0;
                    dmem_rdata <= '0;
                    if ((|dmem_rmask) || (|dmem_wmask)) begin
                        addr_q  <= dmem_addr[31:2];
                        rmask_q <= dmem_rmask;
                        wmask_q <= dmem_wmask;
                        wdata_q <= dmem_wdata;
                        cnt     <= 4'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        dmem_resp  <= 1'b1;
                        dmem_err   <= req_err;
                        dmem_rdata <= (!req_err && (wmask_q == 4'd0)) ? mem[idx] : 32'd0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    dmem_resp  <= 1'b0;
                    dmem_err   <= 1'b0;
                    dmem_rdata <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 2 and 1) driven
// with directed and random requests, checked against an array-based model.
module tb_dmem_responder;
    localparam int          LAT0 = 2, LAT1 = 1;
    localparam int          DEP0 = 1024, DEP1 = 256;
    localparam logic [31:0] BASE0 = 32'h0000_0000, BASE1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr  [2];
    logic [3:0]  rmask [2];
    logic [3:0]  wmask [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        resp  [2];
    logic        err   [2];
    logic        busy  [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0), .BASE_ADDR(BASE0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr[0]), .dmem_rmask(rmask[0]),
        .dmem_wmask(wmask[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]),
        .dmem_resp(resp[0]), .dmem_err(err[0]), .busy(busy[0]));

    dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr[1]), .dmem_rmask(rmask[1]),
        .dmem_wmask(wmask[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]),
        .dmem_resp(resp[1]), .dmem_err(err[1]), .busy(busy[1]));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl [2][1024];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int lat(int d);   return (d == 0) ? LAT0 : LAT1;   endfunction
    function automatic int depth(int d); return (d == 0) ? DEP0 : DEP1;   endfunction
    function automatic logic [31:0] base(int d); return (d == 0) ? BASE0 : BASE1; endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: legality from the request rules, memory as a plain word array.
    function automatic exp_t model(int d, logic [31:0] a, logic [3:0] rm, logic [3:0] wm,
                                   logic [31:0] wd);
        exp_t   e;
        longint b   = longint'(base(d));
        longint lim = b + 4 * depth(d);
        longint aa  = longint'(a & 32'hFFFF_FFFC);
        int     ix;
        e.err   = (rm != 0 && wm != 0) || aa < b || aa >= lim ||
                  (wm != 0 && !(wm inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}));
        e.rdata = 32'd0;
        if (!e.err) begin
            ix = int'((aa - b) / 4);
            if (wm != 0) begin
                for (int i = 0; i < 4; i++)
                    if (wm[i]) mdl[d][ix][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = mdl[d][ix];
            end
        end
        return e;
    endfunction

    task automatic push(int d, exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: pops on every response; outside responses data/err must be zero.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (resp[d]) begin
                have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    cmp($sformatf("resp_with_empty_queue%0d", d), 32'(resp[d]), 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    cmp($sformatf("rdata%0d", d), rdata[d], e.rdata);
                    cmp($sformatf("err%0d", d), 32'(err[d]), 32'(e.err));
                end
            end else begin
                cmp($sformatf("idle_rdata%0d", d), rdata[d], 32'd0);
                cmp($sformatf("idle_err%0d", d), 32'(err[d]), 32'd0);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
    task automatic req(int d, logic [31:0] a, logic [3:0] rm, logic [3:0] wm,
                       logic [31:0] wd, bit scramble);
        int n;
        push(d, model(d, a, rm, wm, wd));
        addr[d] = a; rmask[d] = rm; wmask[d] = wm; wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        cmp($sformatf("busy_wait%0d", d), 32'(busy[d]), 32'd1);
        if (scramble) begin
            addr[d]  = base(d) + 4 * $urandom_range(0, 9);
            wdata[d] = $urandom;
            rmask[d] = 4'hF;
            wmask[d] = 4'h0;
        end
        n = 0;
        while (!resp[d] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            cmp($sformatf("busy_wait%0d", d), 32'(busy[d]), 32'd1);
        end
        cmp($sformatf("latency%0d", d), n, lat(d));
        rmask[d] = 4'h0; wmask[d] = 4'h0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request held across several responses: one response every LATENCY+2 cycles.
    task automatic hold_test(int d);
        int          l = lat(d);
        int          t = 3 * l + 6;
        logic [31:0] r_act = '0, b_act = '0, r_exp = '0, b_exp = '0;
        logic [31:0] a = base(d) + 32'h10;
        for (int k = 0; k < 3; k++) push(d, model(d, a, 4'hF, 4'h0, 32'd0));
        for (int k = 1; k <= t; k++) b_exp[k] = 1'b1;
        r_exp[l + 1] = 1'b1; r_exp[2*l + 3] = 1'b1; r_exp[3*l + 5] = 1'b1;
        b_exp[l + 2] = 1'b0; b_exp[2*l + 4] = 1'b0; b_exp[3*l + 6] = 1'b0;
        addr[d] = a; rmask[d] = 4'hF; wmask[d] = 4'h0;
        for (int k = 1; k <= t; k++) begin
            @(posedge clk);
            @(negedge clk);
            r_act[k] = resp[d];
            b_act[k] = busy[d];
        end
        rmask[d] = 4'h0;
        cmp($sformatf("hold_resp_pattern%0d", d), r_act, r_exp);
        cmp($sformatf("hold_busy_pattern%0d", d), b_act, b_exp);
    endtask

    task automatic rand_req(int d);
        logic [31:0] a;
        logic [3:0]  rm, wm;
        int          t = $urandom_range(0, 3);
        logic [3:0]  legal [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        a = base(d) + 4 * $urandom_range(0, 9) + $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 0) ? base(d) + 4 * depth(d) + 4 * $urandom_range(0, 3)
                                           : base(d) - 4;
        rm = 4'h0; wm = 4'h0;
        case (t)
            0:       rm = 4'($urandom_range(1, 15));
            1:       wm = legal[$urandom_range(0, 6)];
            2:       wm = 4'($urandom_range(1, 15));
            default: begin rm = 4'($urandom_range(1, 15)); wm = 4'($urandom_range(1, 15)); end
        endcase
        req(d, a, rm, wm, $urandom, ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt_resp;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; rmask[d] = '0; wmask[d] = '0; wdata[d] = '0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("rst_resp%0d", d),  32'(resp[d]), 32'd0);
            cmp($sformatf("rst_busy%0d", d),  32'(busy[d]), 32'd0);
            cmp($sformatf("rst_err%0d", d),   32'(err[d]),  32'd0);
            cmp($sformatf("rst_rdata%0d", d), rdata[d],     32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 10; k++)
                req(d, base(d) + 4 * k, 4'h0, 4'hF, $urandom, 1'b0);

        req(0, 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        req(0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);
        req(0, 32'h10, 4'h0, 4'h2, 32'h0000AA00, 1'b0);
        req(0, 32'h10, 4'h0, 4'hC, 32'h12340000, 1'b0);
        req(0, 32'h10, 4'h1, 4'h0, 32'h0, 1'b0);

        req(0, 32'h10, 4'hF, 4'h1, 32'hFFFFFFFF, 1'b0);
        req(0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);
        req(0, BASE0 + 4 * DEP0, 4'hF, 4'h0, 32'h0, 1'b0);
        req(0, 32'h14, 4'h0, 4'h6, 32'hFFFFFFFF, 1'b0);
        req(0, 32'h14, 4'hF, 4'h0, 32'h0, 1'b0);
        req(1, BASE1 - 4, 4'hF, 4'h0, 32'h0, 1'b0);
        req(1, BASE1 + 4 * DEP1, 4'hF, 4'h0, 32'h0, 1'b0);
        req(1, BASE1 + 4 * DEP1 - 4, 4'hF, 4'h0, 32'h0, 1'b0);

        hold_test(0);
        hold_test(1);

        req(1, BASE1 + 8, 4'h0, 4'hF, 32'hA5A5_0F0F, 1'b1);
        req(1, BASE1 + 8, 4'hF, 4'h0, 32'h0, 1'b1);
        req(0, BASE0 + 12, 4'h0, 4'h3, 32'h0000_C3C3, 1'b1);
        req(0, BASE0 + 12, 4'hF, 4'h0, 32'h0, 1'b1);

        req(0, 32'h20, 4'h0, 4'hF, 32'h0BADF00D, 1'b0);
        addr[0] = 32'h20; wmask[0] = 4'hF; wdata[0] = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        cmp("busy_before_reset", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("async_rst_busy",  32'(busy[0]), 32'd0);
        cmp("async_rst_resp",  32'(resp[0]), 32'd0);
        cmp("async_rst_err",   32'(err[0]),  32'd0);
        cmp("async_rst_rdata", rdata[0],     32'd0);
        wmask[0] = 4'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cnt_resp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp[0]) cnt_resp++;
        end
        cmp("resp_after_reset", cnt_resp, 0);
        req(0, 32'h20, 4'hF, 4'h0, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rand_req(0);
            rand_req(1);
        end

        repeat (5) @(negedge clk);
        cmp("queue0_drained", q0.size(), 0);
        cmp("queue1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the CPU data port driven by the execute stage (dmem_addr / rmask / wmask / wdata in, dmem_rdata / dmem_resp out).
- Holds a word-addressed, byte-writable array behind a small control FSM with programmable fixed latency.
- Used as the single-outstanding data memory in pipeline-level simulation and FPGA builds.
- Flags out-of-range and malformed requests to the requester.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 2, cycles from request acceptance to dmem_resp; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dmem_addr  in  32  byte address; bits [1:0] are ignored (requester word-aligns).
- dmem_rmask  in  4  byte read mask; nonzero means read request.
- dmem_wmask  in  4  byte write mask; nonzero means write request.
- dmem_wdata  in  32  write data, already lane-shifted by the requester.
- dmem_rdata  out  32  read data, valid only while dmem_resp=1.
- dmem_resp  out  1  one-cycle response pulse.
- dmem_err  out  1  one-cycle pulse coincident with dmem_resp when the request was illegal.
- busy  out  1  high from the acceptance edge up to and including the response cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - dmem_resp=0, dmem_err=0, busy=0, dmem_rdata=0, latency counter=0.
  - The array is not reset.
- Requester contract:
  - Holds addr/masks/wdata stable from presentation until the cycle dmem_resp=1.
  - May change or drop the request in the following cycle.
- FSM states:
  - IDLE:
    - At a rising edge with (rmask|wmask)!=0, register addr/rmask/wmask/wdata.
    - Load counter with LATENCY-1 and go to WAIT.
    - Zero masks: stay in IDLE.
  - WAIT:
    - Decrement the counter each edge.
    - When counter==0 at an edge, perform the access and go to RESP.
    - For LATENCY=1, WAIT lasts exactly one cycle.
  - RESP:
    - dmem_resp=1 for exactly one cycle; always returns to IDLE.
    - A request presented during RESP is NOT accepted; it can be accepted at the IDLE edge one cycle later. This prevents re-accepting the held request.
- Latency: request accepted at edge N gives dmem_resp=1 during the cycle following edge N+LATENCY. Back-to-back throughput is one request per LATENCY+2 cycles.
- Access and commit point: the access is performed at the WAIT->RESP edge, on the registered request only. Inputs changing during WAIT have no effect.
- Read: dmem_rdata = full 32-bit word at index (addr-BASE_ADDR)>>2, regardless of which rmask bits are set. The requester extracts and extends the bytes.
- Write:
  - For each i with wmask[i]=1, byte i of the word := wdata[8i+7:8i]; other bytes are unchanged.
  - dmem_rdata=0 in the response cycle.
- Illegal requests, all of which produce a response with dmem_err=1, dmem_rdata=0 and no array change:
  - Both rmask and wmask nonzero.
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - wmask not one of 0001/0010/0100/1000/0011/1100/1111.
- dmem_rdata returns to 0 when dmem_resp=0.
- Reset mid-operation (rst_n low during WAIT): the pending access is cancelled, no array write occurs, and no response is issued after reset release.
- Address arithmetic: index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. The range check uses the full 32-bit subtract with borrow, so addresses below BASE_ADDR do not wrap into range.

Test Plan:
- Write then read, LATENCY=2: write addr=0x10, wmask=1111, wdata=0xDEADBEEF at edge 0 -> resp during cycle after edge 2, rdata=0, err=0. Then read addr=0x10, rmask=1111 -> rdata=0xDEADBEEF.
- Byte/half merge: after the word above, sb wmask=0010 wdata=0x0000AA00, then sh wmask=1100 wdata=0x12340000 -> read addr=0x10 returns 0x1234AAEF.
- Hold/no re-accept: keep the read request asserted for 3 cycles after resp -> exactly one resp per LATENCY+2 cycles, and busy drops for exactly one cycle between responses.
- Illegal: rmask=1111 with wmask=0001 -> err=1 with resp, rdata=0, memory word unchanged. addr=BASE_ADDR+4*DEPTH_WORDS -> err=1. wmask=0110 -> err=1.
- Reset mid-op: accept write 0x55555555 to addr=0x20, pull rst_n low during WAIT -> outputs go to 0 immediately (async), no resp after release, and a subsequent read of 0x20 does not return 0x55555555.
- LATENCY=1 sweep: accept at edge N -> resp in cycle after edge N+1. Inputs changed during WAIT are ignored: the registered address, not the new one, is accessed.
